spi_adc_scanner: RTL and testbench

- Parametrised SPI master for MCP300x-family successive-approximation ADCs; successor to the fixed 10-bit, 2-channel, differential-only converter interface.
- Adds per-request channel select, single-ended/differential mode, a programmable SCLK divider, a reset, and a tagged valid/busy handshake.
- Sits between the sampling logic (one request at a time) and the board ADC pins.

---
 rtl/adc_pkg.sv | 17 +
 rtl/spi_clk_gen.sv | 35 +++
 rtl/spi_adc_scanner.sv | 170 +++++++++++++++++
 tb/tb_spi_adc_scanner.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and frame-geometry helpers for the MCP300x SPI ADC scanner.
package adc_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic START_BIT = 1'b1;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // SCLK periods per frame: start + SGL/DIFF + channel bits + null bits + result
  function automatic int nbits(input int num_ch, input int null_bits, input int data_w);
    return 2 + ch_w(num_ch) + null_bits + data_w;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clk cycles while enabled, with
// one-cycle strobes flagging the clk edge on which sclk rises or falls.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic             tick;

  assign tick      = en && (cnt == DIV_LAST);
  assign sclk_rise = tick && !sclk;
  assign sclk_fall = tick && sclk;

  // Leaving SHIFT parks the divider so the next frame starts from a clean low phase
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
      if (tick) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_adc_scanner.sv
// SPI master for MCP300x-family SAR ADCs with per-request channel/mode select.
// Define ADC_SCAN_EN to add the scan input for automatic round-robin conversion.
module spi_adc_scanner
  import adc_pkg::*;
#(
  parameter  int DATA_W    = 10,
  parameter  int NUM_CH    = 2,
  parameter  int CLK_DIV   = 4,
  parameter  int NULL_BITS = 1,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   ch,
  input  logic              diff,
`ifdef ADC_SCAN_EN
  input  logic              scan,
`endif
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic [CH_W-1:0]   dout_ch,
  output logic              err,
  output logic              adc_cs,
  output logic              adc_clk,
  output logic              adc_din,
  input  logic              adc_dout
);

  localparam int NB       = nbits(NUM_CH, NULL_BITS, DATA_W);
  localparam int CMD_BITS = 2 + CH_W;
  localparam int BIT_W    = $clog2(NB + 1);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BIT_W-1:0] SKIP_V   = BIT_W'(CMD_BITS + NULL_BITS);
  localparam logic [BIT_W-1:0] LAST_V   = BIT_W'(NB - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CH_W:0]    NUM_CH_V = NUM_CH[CH_W:0];
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic                accept, reject, cont_q;
  logic                scan_en, wait_done, last_bit;
  logic                sclk_rise, sclk_fall;
  logic [DIV_W-1:0]    wait_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CH_W-1:0]     ch_q, next_ch;
  logic                diff_q;
  logic [CMD_BITS-2:0] cmd_sr;
  logic [DATA_W-1:0]   res_sr;

`ifdef ADC_SCAN_EN
  assign scan_en = scan;
`else
  assign scan_en = 1'b0;
`endif

  assign wait_done = (wait_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == LAST_V);
  assign next_ch   = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == SHIFT),
    .sclk     (adc_clk),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, ch} < NUM_CH_V) begin
            accept  = 1'b1;
            state_d = SETUP;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      SETUP:   if (wait_done) state_d = SHIFT;
      SHIFT:   if (sclk_fall && last_bit) state_d = HOLD;
      HOLD:    if (wait_done) state_d = DONE;
      DONE:    state_d = cont_q ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      valid    <= 1'b0;
      err      <= 1'b0;
      dout     <= '0;
      dout_ch  <= '0;
      adc_cs   <= 1'b1;
      adc_din  <= 1'b0;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      ch_q     <= '0;
      diff_q   <= 1'b0;
      cmd_sr   <= '0;
      res_sr   <= '0;
      cont_q   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= reject;
      if (state_q == SETUP || state_q == HOLD) wait_cnt <= wait_done ? '0 : wait_cnt + DIV_W'(1);
      else                                     wait_cnt <= '0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            ch_q    <= ch;
            diff_q  <= diff;
            cmd_sr  <= {~diff, ch};
            bit_cnt <= '0;
            busy    <= 1'b1;
            adc_cs  <= 1'b0;
            adc_din <= START_BIT;
          end
        end
        SHIFT: begin
          if (sclk_rise && bit_cnt >= SKIP_V) res_sr <= {res_sr[DATA_W-2:0], adc_dout};
          // Command bits leave MSB first; zeros follow once the command is exhausted
          if (sclk_fall) begin
            adc_din <= cmd_sr[CMD_BITS-2];
            cmd_sr  <= {cmd_sr[CMD_BITS-3:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (last_bit) adc_cs <= 1'b1;
          end
        end
        HOLD: begin
          // A scan continuation drops CS here so the CS-high gap is exactly HOLD
          if (wait_done && scan_en) begin
            cont_q  <= 1'b1;
            adc_cs  <= 1'b0;
            adc_din <= START_BIT;
          end
        end
        DONE: begin
          valid   <= 1'b1;
          dout    <= res_sr;
          dout_ch <= ch_q;
          cont_q  <= 1'b0;
          if (cont_q) begin
            ch_q    <= next_ch;
            cmd_sr  <= {~diff_q, next_ch};
            bit_cnt <= '0;
          end else begin
            busy    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench for spi_adc_scanner: default, wide, and error-check instances,
// plus a scan-mode instance when ADC_SCAN_EN is defined.
module tb_spi_adc_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Instance 0: defaults (DATA_W=10, NUM_CH=2, CLK_DIV=4, NULL_BITS=1)
  logic        start0 = 1'b0, ch0 = 1'b0, diff0 = 1'b0;
  logic        busy0, valid0, err0, adc_cs0, adc_clk0, adc_din0;
  logic        adc_dout0 = 1'b1;
  logic [9:0]  dout0, val0 = '0;
  logic        dout_ch0;

  spi_adc_scanner u0 (
    .clk(clk), .rst(rst), .start(start0), .ch(ch0), .diff(diff0),
`ifdef ADC_SCAN_EN
    .scan(1'b0),
`endif
    .busy(busy0), .valid(valid0), .dout(dout0), .dout_ch(dout_ch0), .err(err0),
    .adc_cs(adc_cs0), .adc_clk(adc_clk0), .adc_din(adc_din0), .adc_dout(adc_dout0)
  );

  // Instance 1: NUM_CH=8, DATA_W=12, CLK_DIV=1
  logic        start1 = 1'b0, diff1 = 1'b0;
  logic [2:0]  ch1 = '0, dout_ch1;
  logic        busy1, valid1, err1, adc_cs1, adc_clk1, adc_din1;
  logic        adc_dout1 = 1'b1;
  logic [11:0] dout1, val1 = '0;

  spi_adc_scanner #(.DATA_W(12), .NUM_CH(8), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .ch(ch1), .diff(diff1),
`ifdef ADC_SCAN_EN
    .scan(1'b0),
`endif
    .busy(busy1), .valid(valid1), .dout(dout1), .dout_ch(dout_ch1), .err(err1),
    .adc_cs(adc_cs1), .adc_clk(adc_clk1), .adc_din(adc_din1), .adc_dout(adc_dout1)
  );

  // Instance 2: NUM_CH=6 for out-of-range requests
  logic        start2 = 1'b0;
  logic [2:0]  ch2 = '0, dout_ch2;
  logic        busy2, valid2, err2, adc_cs2, adc_clk2, adc_din2;
  logic [9:0]  dout2;

  spi_adc_scanner #(.NUM_CH(6), .CLK_DIV(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .ch(ch2), .diff(1'b0),
`ifdef ADC_SCAN_EN
    .scan(1'b0),
`endif
    .busy(busy2), .valid(valid2), .dout(dout2), .dout_ch(dout_ch2), .err(err2),
    .adc_cs(adc_cs2), .adc_clk(adc_clk2), .adc_din(adc_din2), .adc_dout(1'b0)
  );

`ifdef ADC_SCAN_EN
  logic        start3 = 1'b0, scan3 = 1'b0;
  logic [1:0]  ch3 = '0, dout_ch3;
  logic        busy3, valid3, err3, adc_cs3, adc_clk3, adc_din3;
  logic [9:0]  dout3;
  int          chq3[$];
  int          gaps3[$];
  int          run3 = 0;
  bit          seen3 = 1'b0;

  spi_adc_scanner #(.NUM_CH(4), .CLK_DIV(2)) u3 (
    .clk(clk), .rst(rst), .start(start3), .ch(ch3), .diff(1'b0), .scan(scan3),
    .busy(busy3), .valid(valid3), .dout(dout3), .dout_ch(dout_ch3), .err(err3),
    .adc_cs(adc_cs3), .adc_clk(adc_clk3), .adc_din(adc_din3), .adc_dout(1'b1)
  );

  always @(posedge clk) if (valid3) chq3.push_back(int'(dout_ch3));

  always @(negedge clk) begin
    if (adc_cs3 === 1'b0) begin
      if (seen3 && run3 > 0) gaps3.push_back(run3);
      seen3 = 1'b1;
      run3  = 0;
    end else begin
      run3++;
    end
  end
`endif

  // ADC models: result MSB appears in the period after command + null bits
  int          per0 = 0, rise0 = 0, nval0 = 0;
  logic [31:0] cmd0 = '0;
  always @(negedge adc_cs0) begin per0 = 0; rise0 = 0; cmd0 = '0; adc_dout0 = 1'b1; end
  always @(posedge adc_clk0) begin rise0++; cmd0 = {cmd0[30:0], adc_din0}; end
  always @(negedge adc_clk0) begin
    per0++;
    if (per0 >= 4 && per0 < 14) adc_dout0 = val0[4'(13 - per0)];
    else                        adc_dout0 = 1'b1;
  end
  always @(posedge clk) if (valid0) nval0++;

  int          per1 = 0, rise1 = 0;
  logic [31:0] cmd1 = '0;
  always @(negedge adc_cs1) begin per1 = 0; rise1 = 0; cmd1 = '0; adc_dout1 = 1'b1; end
  always @(posedge adc_clk1) begin rise1++; cmd1 = {cmd1[30:0], adc_din1}; end
  always @(negedge adc_clk1) begin
    per1++;
    if (per1 >= 6 && per1 < 18) adc_dout1 = val1[4'(17 - per1)];
    else                        adc_dout1 = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic wait_valid0(output int lat);
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); @(negedge clk);
      if (valid0) begin lat = k; break; end
    end
  endtask

  task automatic wait_valid1(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); @(negedge clk);
      if (valid1) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat;
    int nv;
    int exp_seq[5];

    // Reset state
    @(negedge clk);
    cyc(3);
    chk("rst_cs", adc_cs0, 1);
    chk("rst_sclk", adc_clk0, 0);
    chk("rst_din", adc_din0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_err", err0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_dout_ch", dout_ch0, 0);
    rst = 1'b0;
    cyc(2);

    // Single-ended ch1 conversion on defaults
    val0 = 10'h2A5; ch0 = 1'b1; diff0 = 1'b0; start0 = 1'b1;
    cyc(1);
    start0 = 1'b0;
    chk("t1_busy", busy0, 1);
    chk("t1_cs", adc_cs0, 0);
    chk("t1_din", adc_din0, 1);
    wait_valid0(lat);
    chk("t1_latency", lat, 121);
    chk("t1_dout", dout0, 10'h2A5);
    chk("t1_dout_ch", dout_ch0, 1);
    chk("t1_busy_end", busy0, 0);
    chk("t1_periods", rise0, 14);
    chk("t1_cmd", cmd0[13:0], 14'h3800);
    cyc(1);
    chk("t1_valid_pulse", valid0, 0);
    chk("t1_dout_hold", dout0, 10'h2A5);

    // Differential ch0 with a stray start at T0+20
    nv = nval0;
    val0 = 10'h15A; ch0 = 1'b0; diff0 = 1'b1; start0 = 1'b1;
    cyc(1);
    start0 = 1'b0;
    cyc(19);
    start0 = 1'b1; ch0 = 1'b1; diff0 = 1'b0;
    cyc(1);
    start0 = 1'b0;
    chk("t2_busy", busy0, 1);
    wait_valid0(lat);
    chk("t2_latency", lat, 101);
    chk("t2_dout", dout0, 10'h15A);
    chk("t2_dout_ch", dout_ch0, 0);
    chk("t2_cmd", cmd0[13:0], 14'h2000);
    cyc(150);
    chk("t2_one_valid", nval0 - nv, 1);
    chk("t2_cs_idle", adc_cs0, 1);

    // Reset at T0+50, then a clean conversion
    val0 = 10'h3C3; ch0 = 1'b1; diff0 = 1'b0; start0 = 1'b1;
    cyc(1);
    start0 = 1'b0;
    cyc(49);
    rst = 1'b1;
    cyc(1);
    chk("t3_cs", adc_cs0, 1);
    chk("t3_sclk", adc_clk0, 0);
    chk("t3_busy", busy0, 0);
    chk("t3_din", adc_din0, 0);
    chk("t3_dout", dout0, 0);
    rst = 1'b0;
    nv = nval0;
    cyc(200);
    chk("t3_no_valid", nval0 - nv, 0);
    start0 = 1'b1;
    cyc(1);
    start0 = 1'b0;
    wait_valid0(lat);
    chk("t3_latency", lat, 121);
    chk("t3_dout", dout0, 10'h3C3);
    chk("t3_dout_ch", dout_ch0, 1);

    // Wide instance, start held high for back-to-back frames
    val1 = 12'hFFF; ch1 = 3'd5; diff1 = 1'b1; start1 = 1'b1;
    cyc(1);
    chk("t4_busy", busy1, 1);
    chk("t4_din", adc_din1, 1);
    wait_valid1(lat);
    chk("t4_latency", lat, 39);
    chk("t4_dout", dout1, 12'hFFF);
    chk("t4_dout_ch", dout_ch1, 5);
    chk("t4_periods", rise1, 18);
    chk("t4_cmd", cmd1[17:0], 18'h2A000);
    chk("t4_busy_end", busy1, 0);
    val1 = 12'h000;
    cyc(1);
    chk("t5_reaccept_busy", busy1, 1);
    chk("t5_reaccept_cs", adc_cs1, 0);
    start1 = 1'b0;
    wait_valid1(lat);
    chk("t5_latency", lat, 39);
    chk("t5_dout", dout1, 12'h000);
    chk("t5_dout_ch", dout_ch1, 5);

    // Out-of-range channels on NUM_CH=6
    ch2 = 3'd7; start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    chk("t6_err", err2, 1);
    chk("t6_cs", adc_cs2, 1);
    chk("t6_busy", busy2, 0);
    cyc(1);
    chk("t6_err_pulse", err2, 0);
    ch2 = 3'd6; start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    chk("t6_err_ch6", err2, 1);
    chk("t6_busy_ch6", busy2, 0);
    ch2 = 3'd5; start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    chk("t6_ok_err", err2, 0);
    chk("t6_ok_busy", busy2, 1);

`ifdef ADC_SCAN_EN
    // Round-robin scan over four channels
    scan3 = 1'b1; ch3 = 2'd0; start3 = 1'b1;
    cyc(1);
    start3 = 1'b0;
    for (int k = 0; k < 2000 && chq3.size() < 4; k++) cyc(1);
    scan3 = 1'b0;
    cyc(300);
    exp_seq = '{0, 1, 2, 3, 0};
    chk("t7_frames", chq3.size(), 5);
    for (int i = 0; i < 5; i++) chk("t7_dout_ch", chq3[i], exp_seq[i]);
    chk("t7_gaps", gaps3.size(), 4);
    for (int i = 0; i < 4; i++) chk("t7_cs_gap", gaps3[i], 2);
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
